// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm -- single-byte I2C master.
//
// Each transaction is START, a 7-bit address with R/W in bit 0, one data byte
// (written or read), then STOP. SCL is produced by a quarter-period divider
// running on clk_in. The master does no clock stretching and no arbitration.
//
// Optional build macro: I2C_NACK_RETRY_EN. When it is defined, an address NACK
// triggers STOP, then an idle gap, then a repeat of START plus the address.
// This happens up to MAX_RETRY times, and busy stays high throughout.
//
// Ports:
//   clk_in     system clock
//   rst_in     synchronous active-high reset
//   start_req  single-cycle request, accepted only when idle
//   dev_addr   7-bit target address
//   rw         1 = read, 0 = write
//   wr_data    byte to write
//   rd_data    last byte read (holds on writes and NACKs)
//   busy       transaction in progress
//   done       one-cycle pulse, in the first cycle busy is low
//   ack_err    slave NACKed the address or the write data; holds until next start
//   i2c_scl    serial clock, push-pull
//   i2c_sda    serial data, open-drain (driven 0 or released)
module i2c_master_fsm #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_req,
  input  logic [6:0] dev_addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       i2c_scl,
  inout  wire        i2c_sda
);

  localparam int DW  = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  localparam int RCW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

`ifdef I2C_NACK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
    S_WR_ACK, S_READ, S_RD_NACK, S_STOP, S_GAP
  } state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  div_cnt;
  logic [1:0]     qtr;
  logic [2:0]     bit_cnt;
  logic [7:0]     addr_byte;   // {dev_addr, rw}
  logic [7:0]     wr_byte;
  logic [7:0]     shreg;
  logic           sda_smp;
  logic [RCW-1:0] retry_cnt;
  logic           retry_pend;

  logic tick, smp, cell_end, cell_scl, retry_avail;
  logic scl_c, sda_low_c;

  assign tick     = (div_cnt == DW'(CLK_DIV - 1));
  assign smp      = tick && (qtr == 2'd2);   // last cycle of q2
  assign cell_end = tick && (qtr == 2'd3);
  assign cell_scl = qtr[0] ^ qtr[1];         // high in q1 and q2 only
  assign retry_avail = RETRY_EN && (retry_cnt != RCW'(MAX_RETRY));

  // The bus pins are decoded from registered state only. Reset returns the
  // FSM to IDLE, so the line is released with SCL high on the next edge.
  assign i2c_scl = scl_c;
  assign i2c_sda = sda_low_c ? 1'b0 : 1'bz;

  always_comb begin
    state_nxt = state;
    scl_c     = 1'b1;
    sda_low_c = 1'b0;
    case (state)
      S_IDLE: if (start_req) state_nxt = S_START;
      S_START: begin
        sda_low_c = qtr[1];                  // SDA falls halfway through a high SCL
        if (cell_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        scl_c     = cell_scl;
        sda_low_c = ~addr_byte[bit_cnt];
        if (cell_end && bit_cnt == 3'd0) state_nxt = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_c = cell_scl;
        if (cell_end)
          state_nxt = sda_smp ? S_STOP : (addr_byte[0] ? S_READ : S_WRITE);
      end
      S_WRITE: begin
        scl_c     = cell_scl;
        sda_low_c = ~wr_byte[bit_cnt];
        if (cell_end && bit_cnt == 3'd0) state_nxt = S_WR_ACK;
      end
      S_WR_ACK: begin
        scl_c = cell_scl;
        if (cell_end) state_nxt = S_STOP;
      end
      S_READ: begin
        scl_c = cell_scl;
        if (cell_end && bit_cnt == 3'd0) state_nxt = S_RD_NACK;
      end
      S_RD_NACK: begin
        scl_c = cell_scl;                    // released SDA = master NACK
        if (cell_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        scl_c     = (qtr != 2'd0);
        sda_low_c = ~qtr[1];                 // SDA rises while SCL is high
        if (cell_end) state_nxt = retry_pend ? S_GAP : S_IDLE;
      end
      S_GAP: if (cell_end) state_nxt = S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      qtr        <= 2'd0;
      bit_cnt    <= 3'd7;
      addr_byte  <= 8'h00;
      wr_byte    <= 8'h00;
      shreg      <= 8'h00;
      sda_smp    <= 1'b1;
      rd_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == S_IDLE) begin
        if (start_req) begin
          addr_byte  <= {dev_addr, rw};
          wr_byte    <= wr_data;
          ack_err    <= 1'b0;
          busy       <= 1'b1;
          div_cnt    <= '0;
          qtr        <= 2'd0;
          bit_cnt    <= 3'd7;
          retry_cnt  <= '0;
          retry_pend <= 1'b0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) qtr <= qtr + 2'd1;
        if (smp) begin
          sda_smp <= i2c_sda;
          if (state == S_READ) shreg <= {shreg[6:0], i2c_sda};
        end
        if (cell_end) begin
          // After bit 0 the counter wraps to 7, which is the right start
          // value for the next byte or a retried address.
          if (state == S_ADDR || state == S_WRITE || state == S_READ)
            bit_cnt <= bit_cnt - 3'd1;
          // By the end of the last cell, shreg already holds all 8 bits.
          if (state == S_READ && bit_cnt == 3'd0) rd_data <= shreg;
          if (state == S_ADDR_ACK && sda_smp) begin
            if (retry_avail) begin
              retry_pend <= 1'b1;
              retry_cnt  <= retry_cnt + RCW'(1);
            end else begin
              ack_err <= 1'b1;
            end
          end
          if (state == S_WR_ACK && sda_smp) ack_err <= 1'b1;
          if (state == S_GAP) retry_pend <= 1'b0;
          if (state == S_STOP && !retry_pend) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm. A quarter-period schedule of the expected bus
// waveform is built for each accepted request. The same schedule tells the
// simulated slave when to pull SDA low, and every cycle is compared against it.
module tb_i2c_master_fsm;
  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 3;
  localparam int MAXQ      = 256;
`ifdef I2C_NACK_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  logic       clk_in = 1'b0, rst_in = 1'b1, start_req = 1'b0, rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       busy, done, ack_err, i2c_scl;
  wire        i2c_sda;
  logic       slave_pull;

  pullup (i2c_sda);
  assign i2c_sda = slave_pull ? 1'b0 : 1'bz;

  i2c_master_fsm #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_req(start_req), .dev_addr(dev_addr),
    .rw(rw), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
    .ack_err(ack_err), .i2c_scl(i2c_scl), .i2c_sda(i2c_sda)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave plan for the next request ----------------
  logic [3:0] p_nack_mask = 4'h0;   // bit i: address attempt i is NACKed
  logic       p_data_nack = 1'b0;
  logic [7:0] p_rd_byte   = 8'h00;

  // ---------------- behavioural model ----------------
  bit   q_scl [MAXQ];
  bit   q_sda [MAXQ];
  bit   q_pull[MAXQ];
  int   nq, m_k, m_len;
  bit   m_busy = 0, m_done = 0, m_ack = 0, f_ack;
  logic [7:0] m_rd = 8'h00, f_rd;
  bit   chk_en = 0;

  task automatic add_q(input bit s, input bit d, input bit p);
    q_scl[nq] = s; q_sda[nq] = d; q_pull[nq] = p; nq++;
  endtask
  task automatic add_bit(input bit d, input bit p);
    add_q(0, d, p); add_q(1, d, p); add_q(1, d, p); add_q(0, d, p);
  endtask
  task automatic add_stop();
    add_q(0, 0, 0); add_q(1, 0, 0); add_q(1, 1, 0); add_q(1, 1, 0);
  endtask

  task automatic build(input logic [6:0] a, input logic r, input logic [7:0] w);
    logic [7:0] ab;
    bit nk;
    ab = {a, r}; nq = 0; f_ack = 0; f_rd = m_rd; nk = 1;
    for (int att = 0; att <= RETRIES; att++) begin
      add_q(1, 1, 0); add_q(1, 1, 0); add_q(1, 0, 0); add_q(1, 0, 0);
      for (int i = 7; i >= 0; i--) add_bit(ab[i], 0);
      nk = p_nack_mask[att];
      add_bit(nk, !nk);
      if (!nk) break;
      if (att < RETRIES) begin
        add_stop();
        for (int j = 0; j < 4; j++) add_q(1, 1, 0);
      end else f_ack = 1;
    end
    if (!nk) begin
      if (!r) begin
        for (int i = 7; i >= 0; i--) add_bit(w[i], 0);
        add_bit(p_data_nack, !p_data_nack);
        f_ack = p_data_nack;
      end else begin
        for (int i = 7; i >= 0; i--) add_bit(p_rd_byte[i], !p_rd_byte[i]);
        add_bit(1, 0);
        f_rd = p_rd_byte;
      end
    end
    add_stop();
    m_len = nq * CLK_DIV;
  endtask

  initial forever begin : model
    bit was_busy;
    @(posedge clk_in);
    if (rst_in) begin
      m_busy = 0; m_done = 0; m_ack = 0; m_rd = 8'h00; m_k = 0;
    end else begin
      was_busy = m_busy;
      m_done = 0;
      if (m_busy) begin
        m_k++;
        if (m_k == m_len) begin
          m_busy = 0; m_done = 1; m_ack = f_ack; m_rd = f_rd;
        end
      end
      if (!was_busy && start_req) begin
        build(dev_addr, rw, wr_data);
        m_busy = 1; m_k = 0; m_ack = 0;
      end
    end
  end

  assign slave_pull = m_busy && q_pull[m_k / CLK_DIV];

  // ---------------- per-cycle compare ----------------
  initial forever begin : compare
    @(negedge clk_in);
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("scl", i2c_scl, m_busy ? q_scl[m_k / CLK_DIV] : 1'b1);
      chk("sda", i2c_sda, m_busy ? q_sda[m_k / CLK_DIV] : 1'b1);
      if (!m_busy) begin
        chk("ack_err", ack_err, m_ack);
        chk("rd_data", rd_data, m_rd);
      end
    end
  end

  // ---------------- bus monitor for literal checks ----------------
  int busy_cyc = 0, done_cnt = 0;
  bit bits[$];
  logic scl_d = 1'b1;
  initial forever begin : monitor
    @(negedge clk_in);
    if (busy === 1'b1) busy_cyc++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && i2c_scl && !scl_d) bits.push_back(i2c_sda);
    scl_d = i2c_scl;
  end

  task automatic clear_mon();
    busy_cyc = 0; done_cnt = 0; bits.delete();
  endtask

  function automatic logic [7:0] qbyte(input int off);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      if (off + i < bits.size()) b[7 - i] = bits[off + i];
    return b;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic [3:0] nm, input logic dn, input logic [7:0] rb);
    p_nack_mask = nm; p_data_nack = dn; p_rd_byte = rb;
    dev_addr = a; rw = r; wr_data = w; start_req = 1'b1;
    @(negedge clk_in);
    start_req = 1'b0;
  endtask

  // Returns at the negedge where done is seen; spur pulses start_req while busy.
  task automatic wait_done(input bit spur);
    for (int t = 0; t < 4000; t++) begin
      if (done === 1'b1) break;
      if (spur && busy === 1'b1 && $urandom_range(0, 30) == 0) begin
        dev_addr = 7'($urandom); start_req = 1'b1;
      end else start_req = 1'b0;
      @(negedge clk_in);
    end
    start_req = 1'b0;
    chk("wait_done", done, 1'b1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_en = 1;
    chk("rst_scl", i2c_scl, 1'b1);
    chk("rst_sda", i2c_sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    rst_in = 1'b0;
    settle();

    // Write 0x50 / 0xA5, both bytes ACKed
    clear_mon();
    start_txn(7'h50, 1'b0, 8'hA5, 4'h0, 1'b0, 8'h00);
    wait_done(0); settle();
    chk("wr_busy_cycles", busy_cyc, 320);
    chk("wr_done_count", done_cnt, 1);
    chk("wr_addr_byte", qbyte(0), 8'hA0);
    chk("wr_data_byte", qbyte(9), 8'hA5);
    chk("wr_ack_err", ack_err, 1'b0);

    // Read 0x50, slave returns 0x3C
    clear_mon();
    start_txn(7'h50, 1'b1, 8'h00, 4'h0, 1'b0, 8'h3C);
    wait_done(0);
    chk("rd_data_at_done", rd_data, 8'h3C);
    settle();
    chk("rd_addr_byte", qbyte(0), 8'hA1);
    chk("rd_master_nack", bits.size() > 17 ? bits[17] : 1'b0, 1'b1);

    // Address NACK on every attempt
    clear_mon();
    start_txn(7'h11, 1'b0, 8'h77, 4'hF, 1'b0, 8'h00);
    wait_done(0); settle();
    chk("nack_busy_cycles", busy_cyc, (RETRIES == 0) ? 176 : 752);
    chk("nack_ack_err", ack_err, 1'b1);
    chk("nack_rd_kept", rd_data, 8'h3C);

    // Data NACK, then a new request clears ack_err
    clear_mon();
    start_txn(7'h22, 1'b0, 8'h5A, 4'h0, 1'b1, 8'h00);
    wait_done(0); settle();
    chk("dnack_ack_err", ack_err, 1'b1);
    chk("dnack_busy_cycles", busy_cyc, 320);
    start_txn(7'h22, 1'b0, 8'h5A, 4'h0, 1'b0, 8'h00);
    chk("ack_err_cleared", ack_err, 1'b0);
    wait_done(0); settle();

    // Reset in the middle of the address byte
    clear_mon();
    start_txn(7'h2A, 1'b0, 8'h55, 4'h0, 1'b0, 8'h00);
    repeat (30) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_scl", i2c_scl, 1'b1);
    chk("midrst_sda", i2c_sda, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rst_in = 1'b0;
    repeat (400) @(negedge clk_in);
    chk("midrst_no_done", done_cnt, 0);

    // start_req while busy is ignored
    clear_mon();
    start_txn(7'h33, 1'b0, 8'hC3, 4'h0, 1'b0, 8'h00);
    repeat (50) @(negedge clk_in);
    start_req = 1'b1; dev_addr = 7'h44;
    @(negedge clk_in);
    start_req = 1'b0;
    wait_done(0);
    repeat (40) @(negedge clk_in);
    chk("spur_busy_cycles", busy_cyc, 320);
    chk("spur_done_count", done_cnt, 1);

    // Randomized traffic, including back-to-back starts on the done cycle
    for (int n = 0; n < 40; n++) begin
      logic [3:0] nm;
      nm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if (n == 0 || $urandom_range(0, 3) != 0) @(negedge clk_in);
      start_txn(7'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), nm,
                ($urandom_range(0, 4) == 0), 8'($urandom));
      wait_done(1);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
